// File: rtl/c_tile_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | c_tile_drain: accepts M x N result tiles and streams them row by row to  |
// | the result memory. Optional K-tile accumulation via `DRAIN_ACCUM_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module c_tile_drain #(
  parameter int M          = 4,
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tile_valid,
  output logic                         tile_ready,
  input  logic [M*N*DATA_WIDTH-1:0]    tile_data,
  input  logic                         tile_last_k,
  input  logic [ADDR_WIDTH-1:0]        tile_base,
  output logic                         wr_valid,
  input  logic                         wr_ready,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [N*DATA_WIDTH-1:0]      wr_data,
  output logic                         wr_last,
  output logic                         busy,
  output logic [15:0]                  tiles_drained
);

  localparam int c_ROW_W = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [M*N*DATA_WIDTH-1:0]   r_buf;
  logic [c_ROW_W-1:0]          r_row;
  logic [ADDR_WIDTH-1:0]       r_base;
  logic [15:0]                 r_cnt;
  logic                        w_accept;
  logic                        w_beat;
  logic                        w_last_row;
  logic                        w_drain_tile;

  assign w_last_row = (r_row == c_ROW_W'(M - 1));

`ifdef DRAIN_ACCUM_EN
  logic                        r_first;
  logic [M*N*DATA_WIDTH-1:0]   w_sum;

  assign w_drain_tile = tile_last_k;

  // Modular elementwise add of the incoming partial tile into the buffer.
  for (genvar e = 0; e < M * N; e++) begin : g_elem
    assign w_sum[e*DATA_WIDTH +: DATA_WIDTH] =
        r_buf[e*DATA_WIDTH +: DATA_WIDTH] + tile_data[e*DATA_WIDTH +: DATA_WIDTH];
  end
`else
  logic                        w_unused_last_k;

  assign w_unused_last_k = tile_last_k;
  assign w_drain_tile    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    tile_ready  = 1'b0;
    wr_valid    = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      S_IDLE: begin
        tile_ready = 1'b1;
        if (tile_valid) begin
          w_accept = 1'b1;
          if (w_drain_tile) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          w_beat = 1'b1;
          if (w_last_row) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_row  <= '0;
      r_base <= '0;
      r_cnt  <= '0;
`ifdef DRAIN_ACCUM_EN
      r_first <= 1'b1;
`endif
    end else begin
      if (w_accept) begin
        r_row <= '0;
`ifdef DRAIN_ACCUM_EN
        // The first K-tile of an output tile owns the base address.
        if (r_first) begin
          r_buf  <= tile_data;
          r_base <= tile_base;
        end else begin
          r_buf  <= w_sum;
        end
        r_first <= 1'b0;
`else
        r_buf  <= tile_data;
        r_base <= tile_base;
`endif
      end
      if (w_beat) begin
        if (w_last_row) begin
          r_row <= '0;
          r_cnt <= r_cnt + 16'd1;
`ifdef DRAIN_ACCUM_EN
          r_first <= 1'b1;
`endif
        end else begin
          r_row <= r_row + c_ROW_W'(1);
        end
      end
    end
  end

  assign wr_addr       = r_base + (ADDR_WIDTH'(r_row) * ADDR_WIDTH'(N));
  assign wr_data       = r_buf[r_row*N*DATA_WIDTH +: N*DATA_WIDTH];
  assign wr_last       = (r_state == S_DRAIN) && w_last_row;
  assign tiles_drained = r_cnt;

`ifdef DRAIN_ACCUM_EN
  assign busy = (r_state == S_DRAIN) || !r_first;
`else
  assign busy = (r_state == S_DRAIN);
`endif

endmodule
`default_nettype wire
